// File: rtl/scientific_calculator.sv
// ----------------------------------------------------------------------------
// scientific_calculator : 3-bit operand calculator, basic and scientific modes
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module scientific_calculator (
  output logic [6:0] C,
  input  logic [2:0] A,
  input  logic [2:0] B,
  input  logic       ms,
  input  logic [2:0] op,
  input  logic       clk,
  input  logic       reset,
  input  logic       equal
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [6:0] C_SAT = 7'd127;

  state_t      state;
  state_t      w_next;
  logic [3:0]  mop;
  logic [2:0]  r_a;
  logic [2:0]  r_b;
  logic [3:0]  r_mop;
  logic        w_capture;
  logic        w_load_c;
  logic [6:0]  w_result;
  logic [8:0]  w_cube;
  logic [6:0]  w_a7;
  logic [6:0]  w_b7;

  assign mop  = {ms, op};
  assign w_a7 = {4'd0, r_a};
  assign w_b7 = {4'd0, r_b};
  assign w_cube = {6'd0, r_a} * {6'd0, r_a} * {6'd0, r_a};

  // Repeated multiply, clamped after every step so the accumulator never overflows
  function automatic logic [6:0] f_pow(input logic [2:0] base, input logic [2:0] ex);
    logic [13:0] acc;
    acc = 14'd1;
    for (int i = 0; i < 7; i++) begin
      if (i < int'(ex)) begin
        acc = acc * {11'd0, base};
        if (acc > 14'd127) acc = 14'd127;
      end
    end
    return acc[6:0];
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      r_a   <= 3'd0;
      r_b   <= 3'd0;
      r_mop <= 4'd0;
      C     <= 7'd0;
    end else begin
      state <= w_next;
      if (w_capture) begin
        r_a   <= A;
        r_b   <= B;
        r_mop <= mop;
      end
      if (w_load_c) C <= w_result;
    end
  end

  always_comb begin
    w_next    = IDLE;
    w_capture = 1'b0;
    w_load_c  = 1'b0;
    case (state)
      IDLE: begin
        if (equal) begin
          w_capture = 1'b1;
          w_next    = EXEC;
        end
      end
      EXEC: begin
        w_load_c = 1'b1;
        w_next   = DONE;
      end
      DONE: begin
        if (equal) begin
          w_capture = 1'b1;
          w_next    = EXEC;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_result = 7'd0;
    case (r_mop)
      4'b0000: w_result = w_a7 + w_b7;
      4'b0001: w_result = w_a7 - w_b7;
      4'b0010: w_result = w_a7 * w_b7;
      4'b0011: w_result = (r_b == 3'd0) ? C_SAT : {4'd0, r_a / r_b};
      4'b0100: w_result = (r_b == 3'd0) ? C_SAT : {4'd0, r_a % r_b};
      4'b0101: w_result = {4'd0, r_a & r_b};
      4'b0110: w_result = {4'd0, r_a | r_b};
      4'b0111: w_result = {4'd0, r_a ^ r_b};
      4'b1000: w_result = w_a7 * w_a7;
      4'b1001: w_result = (w_cube > 9'd127) ? C_SAT : w_cube[6:0];
      4'b1010: w_result = f_pow(r_a, r_b);
      4'b1011: begin
        case (r_a)
          3'd0, 3'd1: w_result = 7'd1;
          3'd2:       w_result = 7'd2;
          3'd3:       w_result = 7'd6;
          3'd4:       w_result = 7'd24;
          3'd5:       w_result = 7'd120;
          default:    w_result = C_SAT;
        endcase
      end
      4'b1100: begin
        case (r_a)
          3'd0:             w_result = 7'd0;
          3'd1, 3'd2, 3'd3: w_result = 7'd1;
          default:          w_result = 7'd2;
        endcase
      end
      4'b1101: begin
        case (r_a)
          3'd0, 3'd1: w_result = 7'd0;
          3'd2, 3'd3: w_result = 7'd1;
          default:    w_result = 7'd2;
        endcase
      end
      // 2^7 = 128 wraps to 0 in 7 bits; this op truncates rather than saturates
      4'b1110: w_result = 7'd1 << r_a;
      4'b1111: w_result = (r_a >= r_b) ? {4'd0, r_a - r_b} : {4'd0, r_b - r_a};
      default: w_result = 7'd0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_scientific_calculator.sv
// ----------------------------------------------------------------------------
// tb_scientific_calculator : directed self-checking bench for scientific_calculator
// Rev 1.0 : initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_scientific_calculator;

  logic [6:0] C;
  logic [2:0] A;
  logic [2:0] B;
  logic       ms;
  logic [2:0] op;
  logic       clk;
  logic       reset;
  logic       equal;

  int n_checks = 0;
  int n_errors = 0;
  logic [6:0] held;

  scientific_calculator dut (
    .C     (C),
    .A     (A),
    .B     (B),
    .ms    (ms),
    .op    (op),
    .clk   (clk),
    .reset (reset),
    .equal (equal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One full transaction: capture, scramble inputs while in flight, check result, return to IDLE
  task automatic run(input string tag, input logic m, input logic [2:0] o,
                     input logic [2:0] a, input logic [2:0] b, input int exp);
    @(negedge clk);
    ms = m; op = o; A = a; B = b; equal = 1'b1;
    @(posedge clk);
    #1;
    A = ~a; B = ~b; op = ~o; ms = ~m; equal = 1'b0;
    chk({tag, "/exec"}, int'(dut.state), 1);
    @(posedge clk);
    #1;
    chk(tag, int'(C), exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    A = 3'd0; B = 3'd0; ms = 1'b0; op = 3'd0; equal = 1'b1;
    reset = 1'b0;
    #1;
    chk("rst_C", int'(C), 0);
    chk("rst_state", int'(dut.state), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    equal = 1'b0;
    reset = 1'b1;

    run("add_3_1",   1'b0, 3'b000, 3'd3, 3'd1, 4);
    run("sub_3_2",   1'b0, 3'b001, 3'd3, 3'd2, 1);
    run("sub_1_3",   1'b0, 3'b001, 3'd1, 3'd3, 126);
    run("mul_7_7",   1'b0, 3'b010, 3'd7, 3'd7, 49);
    run("div_7_2",   1'b0, 3'b011, 3'd7, 3'd2, 3);
    run("div_by0",   1'b0, 3'b011, 3'd5, 3'd0, 127);
    run("mod_7_3",   1'b0, 3'b100, 3'd7, 3'd3, 1);
    run("mod_by0",   1'b0, 3'b100, 3'd4, 3'd0, 127);
    run("and_6_3",   1'b0, 3'b101, 3'd6, 3'd3, 2);
    run("or_4_1",    1'b0, 3'b110, 3'd4, 3'd1, 5);
    run("xor_5_3",   1'b0, 3'b111, 3'd5, 3'd3, 6);
    run("sq_7",      1'b1, 3'b000, 3'd7, 3'd0, 49);
    run("cube_4",    1'b1, 3'b001, 3'd4, 3'd0, 64);
    run("cube_5",    1'b1, 3'b001, 3'd5, 3'd0, 125);
    run("cube_7",    1'b1, 3'b001, 3'd7, 3'd0, 127);
    run("pow_3_2",   1'b1, 3'b010, 3'd3, 3'd2, 9);
    run("pow_7_7",   1'b1, 3'b010, 3'd7, 3'd7, 127);
    run("pow_5_0",   1'b1, 3'b010, 3'd5, 3'd0, 1);
    run("pow_2_6",   1'b1, 3'b010, 3'd2, 3'd6, 64);
    run("pow_2_7",   1'b1, 3'b010, 3'd2, 3'd7, 127);
    run("fact_5",    1'b1, 3'b011, 3'd5, 3'd0, 120);
    run("fact_6",    1'b1, 3'b011, 3'd6, 3'd0, 127);
    run("fact_0",    1'b1, 3'b011, 3'd0, 3'd0, 1);
    run("sqrt_3",    1'b1, 3'b100, 3'd3, 3'd0, 1);
    run("sqrt_7",    1'b1, 3'b100, 3'd7, 3'd0, 2);
    run("log2_5",    1'b1, 3'b101, 3'd5, 3'd0, 2);
    run("log2_0",    1'b1, 3'b101, 3'd0, 3'd0, 0);
    run("exp2_3",    1'b1, 3'b110, 3'd3, 3'd0, 8);
    run("exp2_7",    1'b1, 3'b110, 3'd7, 3'd0, 0);
    run("absd_2_7",  1'b1, 3'b111, 3'd2, 3'd7, 5);

    // Hold: back in IDLE with equal low, C must ignore toggling inputs
    run("hold_seed", 1'b0, 3'b000, 3'd6, 3'd5, 11);
    held = C;
    chk("hold_idle", int'(dut.state), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      A = 3'(i * 3 + 1); B = 3'(i + 5); op = 3'(i); ms = i[0];
    end
    @(posedge clk);
    #1;
    chk("hold_C", int'(C), int'(held));
    chk("hold_state", int'(dut.state), 0);

    // Continuous equal: result refreshes every second edge
    @(negedge clk);
    ms = 1'b0; op = 3'b010; A = 3'd2; B = 3'd3; equal = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("cont_first", int'(C), 6);
    @(negedge clk);
    A = 3'd3;
    repeat (2) @(posedge clk);
    #1;
    chk("cont_second", int'(C), 9);
    chk("cont_done", int'(dut.state), 2);

    // Reset mid-EXEC: immediate clear before any clock edge
    @(negedge clk);
    ms = 1'b0; op = 3'b000; A = 3'd3; B = 3'd1; equal = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_rst_exec", int'(dut.state), 1);
    reset = 1'b0;
    #1;
    chk("async_rst_C", int'(C), 0);
    chk("async_rst_state", int'(dut.state), 0);
    @(posedge clk);
    #1;
    chk("rst_ignore_eq", int'(dut.state), 0);
    @(negedge clk);
    reset = 1'b1;
    equal = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_C", int'(C), 0);
    run("post_rst_add", 1'b0, 3'b000, 3'd2, 3'd2, 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
